coord_transmitter: RTL and testbench
====================================

# coord_transmitter

Serial transmitter for the cursor-coordinate link: latches a 9-bit X, 9-bit Y and a shot flag, then shifts them out as one 20-bit framed, source-synchronous word on three GPIO lines. It is the sending end of the link that `getCoordinates` receives from GPIO. It is used on the sensor/emulator board, and in loopback benches that drive the game's GPIO input.

## Interface
- BIT_CYCLES, 50, Clk cycles per serial bit; even, ≥ 4 (50 → 1 Mbit/s at 50 MHz)
- Clk  in  1  system clock, 50 MHz, all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- send  in  1  request; sampled only while busy=0
- tx_x  in  9  cursor X to send
- tx_y  in  9  cursor Y to send
- tx_shot  in  1  trigger flag to send
- busy  out  1  high from accept until the inter-frame gap ends
- done  out  1  one-cycle pulse at end of frame
- GPIO_SCLK  out  1  serial bit clock, idle low
- GPIO_SDATA  out  1  serial data, MSB first, idle low
- GPIO_FRAME  out  1  high for the full 20 data bits

## Operation
- Frame word, bit 19 down to bit 0: tx_x[8:0], tx_y[8:0], tx_shot, P.
- P is odd parity over the 19 preceding bits, so the total count of ones is odd (P = XNOR-reduce).
- States:
  - IDLE: outputs low, busy=0. If send=1, latch the frame into the shift register and go to SHIFT.
  - SHIFT: transmit the 20 bits, then go to GAP.
  - GAP: hold for 2·BIT_CYCLES cycles, then go to IDLE.
- Inputs are latched only at accept. Changes to tx_* during SHIFT or GAP have no effect.
- send while busy=1 is ignored. There is no queueing.
- If send is held high, frames repeat back-to-back at the minimum spacing.
- Counters:
  - Phase counter: $clog2(BIT_CYCLES) bits, wraps at BIT_CYCLES−1.
  - Bit counter: 5 bits, 0..19.
- Reset low at any edge: the next cycle shows all outputs 0 and state IDLE, and no done is emitted. Any aborted frame is simply truncated; FRAME falls.

## Timing
- Reset values: busy=0, done=0, GPIO_SCLK=0, GPIO_SDATA=0, GPIO_FRAME=0.
- E0 is the edge that samples send=1 in IDLE. After E0: busy=1, FRAME=1, SDATA=bit19, SCLK=0.
- Bit k (k=0 is bit19) occupies the cycles after edges E0+k·BIT_CYCLES through E0+(k+1)·BIT_CYCLES−1.
  - SCLK is low for the first BIT_CYCLES/2 cycles of the bit and high for the second half.
  - SCLK rises after edge E0+k·BIT_CYCLES+BIT_CYCLES/2.
- SDATA changes only together with the SCLK falling edge (bit start). The receiver samples on SCLK rising, giving BIT_CYCLES/2 cycles of setup and hold.
- After edge E0+20·BIT_CYCLES: FRAME=0, SCLK=0, SDATA=0, and done=1 for exactly that one cycle.
- After edge E0+22·BIT_CYCLES: busy=0.
  - The earliest next accept is edge E0+22·BIT_CYCLES+1.
  - Minimum frame-start spacing is therefore 22·BIT_CYCLES+1 cycles.
- Latency from accept to first SCLK rise is BIT_CYCLES/2 cycles.

## Test plan
All scenarios use BIT_CYCLES=4 unless noted.
- **Basic frame.** Reset, then send pulse with tx_x=9'h155, tx_y=9'h0AA, tx_shot=1.
  - Capture SDATA on each SCLK rise → 20'hAAAAB.
  - Exactly 20 SCLK rises while FRAME=1.
  - done pulses once, at cycle 80 after E0.
  - busy falls at cycle 88.
- **Parity extremes.**
  - tx_x=0, tx_y=0, tx_shot=0 → 20'h00001.
  - tx_x=9'h1FF, tx_y=9'h1FF, tx_shot=1 → 20'hFFFFE.
- **Latch and ignore.** Change tx_* and pulse send in the middle of a frame.
  - The transmitted word equals the values latched at accept.
  - No second frame starts.
  - busy timing is unchanged.
- **Held send.** Hold send=1 with constant inputs.
  - Successive FRAME rising edges are exactly 89 cycles apart.
  - One done per frame.
- **Reset mid-frame.** Drive Reset=0 during bit 7.
  - The next cycle shows SCLK=FRAME=SDATA=busy=done=0.
  - No done is ever pulsed for that frame.
  - After Reset=1, a new send produces a correct full frame.
- **Timing with BIT_CYCLES=50.**
  - SCLK high and low phases are each 25 cycles.
  - SDATA is stable for ≥ 25 cycles around each SCLK rise.
  - Frame-start spacing is 1101 cycles.

Source files
------------

// File: rtl/coord_transmitter_if.sv
// rtl/coord_transmitter_if.sv - request/status bundle between a frame source and coord_transmitter
interface coord_transmitter_if;
  logic       send;
  logic [8:0] tx_x;
  logic [8:0] tx_y;
  logic       tx_shot;
  logic       busy;
  logic       done;

  modport master (output send, tx_x, tx_y, tx_shot, input busy, done);
  modport slave  (input send, tx_x, tx_y, tx_shot, output busy, done);
endinterface

// File: rtl/coord_transmitter.sv
// rtl/coord_transmitter.sv - shifts a latched X/Y/shot word out as a 20-bit framed serial link
module coord_transmitter #(
  parameter int BIT_CYCLES = 50
) (
  input  logic                Clk,
  input  logic                Reset,
  coord_transmitter_if.slave  link,
  output logic                GPIO_SCLK,
  output logic                GPIO_SDATA,
  output logic                GPIO_FRAME
);
  localparam int PHASE_W = $clog2(BIT_CYCLES);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(BIT_CYCLES / 2);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state;
  state_t             state_next;
  logic [PHASE_W-1:0] phase;
  logic [4:0]         bit_cnt;
  logic [19:0]        shreg;
  logic               done_q;
  logic               phase_wrap;
  logic               accept;
  logic               frame_end;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= frame_end;
      if (accept) begin
        phase   <= '0;
        bit_cnt <= '0;
        shreg   <= {link.tx_x, link.tx_y, link.tx_shot,
                    ~^{link.tx_x, link.tx_y, link.tx_shot}};
      end else if (state != IDLE) begin
        // The gap reuses the same counters: two bit-times of silence.
        if (phase_wrap) begin
          phase <= '0;
          shreg <= {shreg[18:0], 1'b0};
          if (frame_end || state_next == IDLE) bit_cnt <= '0;
          else                                 bit_cnt <= bit_cnt + 5'd1;
        end else begin
          phase <= phase + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    frame_end  = 1'b0;
    phase_wrap = (phase == PHASE_LAST);
    case (state)
      IDLE: begin
        if (link.send) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_wrap && bit_cnt == 5'd19) begin
          frame_end  = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (phase_wrap && bit_cnt == 5'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign GPIO_FRAME = (state == SHIFT);
  assign GPIO_SCLK  = (state == SHIFT) && (phase >= PHASE_HALF);
  assign GPIO_SDATA = (state == SHIFT) && shreg[19];
  assign link.busy  = (state != IDLE);
  assign link.done  = done_q;
endmodule

// File: tb/tb_coord_transmitter.sv
// tb/tb_coord_transmitter.sv - directed checks of coord_transmitter at BIT_CYCLES 4 and 50
module tb_coord_transmitter;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  coord_transmitter_if if4();
  coord_transmitter_if if50();
  logic sclk4, sdata4, frame4;
  logic sclk50, sdata50, frame50;

  coord_transmitter #(.BIT_CYCLES(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .link(if4),
    .GPIO_SCLK(sclk4), .GPIO_SDATA(sdata4), .GPIO_FRAME(frame4)
  );
  coord_transmitter #(.BIT_CYCLES(50)) dut50 (
    .Clk(Clk), .Reset(Reset), .link(if50),
    .GPIO_SCLK(sclk50), .GPIO_SDATA(sdata50), .GPIO_FRAME(frame50)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    tests = tests + 1;
    if (act < min) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  // Link observer for the BIT_CYCLES=4 instance; cycle counts are relative to the frame rise.
  int          cyc4 = 0, rises4 = 0, dones4 = 0, starts4 = 0;
  int          start_cyc4 = 0, space4 = 0, done_at4 = 0, bfall_at4 = 0;
  logic [19:0] cap4 = '0;
  logic        p_sclk4 = 1'b0, p_frame4 = 1'b0, p_busy4 = 1'b0;

  always @(negedge Clk) begin
    cyc4 = cyc4 + 1;
    if (frame4 && !p_frame4) begin
      if (starts4 > 0) space4 = cyc4 - start_cyc4;
      start_cyc4 = cyc4;
      starts4 = starts4 + 1;
    end
    if (sclk4 && !p_sclk4 && frame4) begin
      cap4 = {cap4[18:0], sdata4};
      rises4 = rises4 + 1;
    end
    if (if4.done) begin
      dones4 = dones4 + 1;
      done_at4 = cyc4 - start_cyc4;
    end
    if (!if4.busy && p_busy4) bfall_at4 = cyc4 - start_cyc4;
    p_sclk4 = sclk4;
    p_frame4 = frame4;
    p_busy4 = if4.busy;
  end

  // Observer for the BIT_CYCLES=50 instance: SCLK run lengths and SDATA setup/hold margins.
  int   cyc50 = 0, rises50 = 0, starts50 = 0, start_cyc50 = 0, space50 = 0, run = 0;
  int   hi_min = 1000000, hi_max = 0, lo_min = 1000000, lo_max = 0;
  int   last_chg = 0, last_rise = 0, setup_min = 1000000, hold_min = 1000000;
  logic have_rise = 1'b0;
  logic p_sclk50 = 1'b0, p_frame50 = 1'b0, p_sdata50 = 1'b0;

  task automatic rec_run(input logic hi, input int n);
    if (hi) begin
      if (n < hi_min) hi_min = n;
      if (n > hi_max) hi_max = n;
    end else begin
      if (n < lo_min) lo_min = n;
      if (n > lo_max) lo_max = n;
    end
  endtask

  always @(negedge Clk) begin
    cyc50 = cyc50 + 1;
    if (frame50 && !p_frame50) begin
      if (starts50 > 0) space50 = cyc50 - start_cyc50;
      start_cyc50 = cyc50;
      starts50 = starts50 + 1;
    end
    if (frame50) begin
      if (p_frame50 && sclk50 == p_sclk50) run = run + 1;
      else begin
        if (p_frame50) rec_run(p_sclk50, run);
        run = 1;
      end
    end else if (p_frame50) begin
      rec_run(p_sclk50, run);
    end
    if (sdata50 != p_sdata50) begin
      if (have_rise && (cyc50 - last_rise) < hold_min) hold_min = cyc50 - last_rise;
      last_chg = cyc50;
    end
    if (sclk50 && !p_sclk50) begin
      rises50 = rises50 + 1;
      if ((cyc50 - last_chg) < setup_min) setup_min = cyc50 - last_chg;
      last_rise = cyc50;
      have_rise = 1'b1;
    end
    p_sclk50 = sclk50;
    p_frame50 = frame50;
    p_sdata50 = sdata50;
  end

  task automatic send4(input logic [8:0] x, input logic [8:0] y, input logic shot);
    @(posedge Clk);
    #1;
    if4.tx_x = x;
    if4.tx_y = y;
    if4.tx_shot = shot;
    if4.send = 1'b1;
    @(posedge Clk);
    #1;
    if4.send = 1'b0;
  endtask

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic        shot;
    logic [19:0] word;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int r0, d0, s0;
    vecs[0] = '{x: 9'h155, y: 9'h0AA, shot: 1'b1, word: 20'hAAAAB};
    vecs[1] = '{x: 9'h000, y: 9'h000, shot: 1'b0, word: 20'h00001};
    vecs[2] = '{x: 9'h1FF, y: 9'h1FF, shot: 1'b1, word: 20'hFFFFE};
    vecs[3] = '{x: 9'h001, y: 9'h000, shot: 1'b0, word: 20'h00800};
    vecs[4] = '{x: 9'h000, y: 9'h000, shot: 1'b1, word: 20'h00002};

    if4.send = 1'b0;  if4.tx_x = '0;  if4.tx_y = '0;  if4.tx_shot = 1'b0;
    if50.send = 1'b0; if50.tx_x = '0; if50.tx_y = '0; if50.tx_shot = 1'b0;

    repeat (3) @(posedge Clk);
    #1;
    check("reset_outputs", {27'd0, sclk4, sdata4, frame4, if4.busy, if4.done}, 32'd0);
    Reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      r0 = rises4; d0 = dones4; s0 = starts4;
      send4(vecs[i].x, vecs[i].y, vecs[i].shot);
      repeat (95) @(posedge Clk);
      #1;
      check($sformatf("v%0d_word", i), cap4, vecs[i].word);
      check($sformatf("v%0d_rises", i), rises4 - r0, 20);
      check($sformatf("v%0d_done_count", i), dones4 - d0, 1);
      check($sformatf("v%0d_done_cycle", i), done_at4, 80);
      check($sformatf("v%0d_busy_fall", i), bfall_at4, 88);
      check($sformatf("v%0d_starts", i), starts4 - s0, 1);
    end

    // Latch and ignore: new inputs plus send pulses in mid-frame must not disturb anything.
    r0 = rises4; d0 = dones4; s0 = starts4;
    send4(9'h123, 9'h045, 1'b0);
    repeat (30) @(posedge Clk);
    #1;
    if4.tx_x = 9'h1FF; if4.tx_y = 9'h1FF; if4.tx_shot = 1'b1; if4.send = 1'b1;
    @(posedge Clk);
    #1;
    if4.send = 1'b0;
    repeat (50) @(posedge Clk);
    #1;
    if4.tx_x = 9'h0AA; if4.send = 1'b1;
    @(posedge Clk);
    #1;
    if4.send = 1'b0;
    repeat (100) @(posedge Clk);
    #1;
    check("latch_word", cap4, 20'h91914);
    check("latch_starts", starts4 - s0, 1);
    check("latch_dones", dones4 - d0, 1);
    check("latch_busy_fall", bfall_at4, 88);

    // Held send: back-to-back frames at minimum spacing.
    d0 = dones4; s0 = starts4;
    @(posedge Clk);
    #1;
    if4.tx_x = 9'h155; if4.tx_y = 9'h0AA; if4.tx_shot = 1'b1; if4.send = 1'b1;
    repeat (267) @(posedge Clk);
    #1;
    if4.send = 1'b0;
    repeat (100) @(posedge Clk);
    #1;
    check("held_starts", starts4 - s0, 3);
    check("held_dones", dones4 - d0, 3);
    check("held_spacing", space4, 89);
    check("held_word", cap4, 20'hAAAAB);

    // Reset during bit 7.
    d0 = dones4;
    send4(9'h0F0, 9'h10F, 1'b0);
    repeat (29) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("midreset_outputs", {27'd0, sclk4, sdata4, frame4, if4.busy, if4.done}, 32'd0);
    Reset = 1'b1;
    repeat (100) @(posedge Clk);
    #1;
    check("midreset_no_done", dones4 - d0, 0);
    r0 = rises4; d0 = dones4;
    send4(vecs[0].x, vecs[0].y, vecs[0].shot);
    repeat (95) @(posedge Clk);
    #1;
    check("after_reset_word", cap4, 20'hAAAAB);
    check("after_reset_rises", rises4 - r0, 20);
    check("after_reset_done", dones4 - d0, 1);

    // BIT_CYCLES=50: two back-to-back frames.
    r0 = rises50; s0 = starts50;
    @(posedge Clk);
    #1;
    if50.tx_x = 9'h155; if50.tx_y = 9'h0AA; if50.tx_shot = 1'b1; if50.send = 1'b1;
    repeat (1200) @(posedge Clk);
    #1;
    if50.send = 1'b0;
    repeat (1200) @(posedge Clk);
    #1;
    check("bc50_starts", starts50 - s0, 2);
    check("bc50_spacing", space50, 1101);
    check("bc50_rises", rises50 - r0, 40);
    check("bc50_hi_min", hi_min, 25);
    check("bc50_hi_max", hi_max, 25);
    check("bc50_lo_min", lo_min, 25);
    check("bc50_lo_max", lo_max, 25);
    check_ge("bc50_setup", setup_min, 25);
    check_ge("bc50_hold", hold_min, 25);
    check("bc50_idle", {31'd0, if50.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
